// File: rtl/fifo_packer.sv
// Packs successive upstream fifo bytes into one PACK-lane word with a valid/ready output.
// Define FIFO_PACKER_PARITY_EN to add the per-lane even-parity output out_parity.
module fifo_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         fifo_data_out,
    input  logic                          fifo_empty,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*PACK-1:0]    out_data,
    output logic [$clog2(PACK+1)-1:0]     out_count
`ifdef FIFO_PACKER_PARITY_EN
    ,
    output logic [PACK-1:0]               out_parity
`endif
);

    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW:0]   PACK_W = (CW + 1)'(PACK);
    localparam logic [CW-1:0] LAST_C = CW'(PACK - 1);

    typedef enum logic {FILL, OUT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   lane_cnt_reg;
    logic            inflight_reg;
    logic            flush_pend_reg;
    logic            started_reg;
    logic [CW:0]     fill_sum;
    logic            last_capture;
    logic            flush_go;
    logic            transfer;

    assign fill_sum     = {1'b0, lane_cnt_reg} + (CW + 1)'(inflight_reg);
    assign last_capture = inflight_reg && (lane_cnt_reg == LAST_C);
    assign flush_go     = flush_pend_reg && !inflight_reg;
    assign transfer     = (state_reg == OUT) && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: if (last_capture || flush_go) state_next = OUT;
            OUT:  if (out_ready)                state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Output logic; started_reg keeps reads off during the first cycle after reset release
    always_comb begin
        fifo_rd_en = (state_reg == FILL) && started_reg && !fifo_empty
                     && (fill_sum < PACK_W) && !flush_pend_reg;
        out_valid  = (state_reg == OUT);
        out_count  = out_valid ? lane_cnt_reg : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt_reg   <= '0;
            inflight_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            started_reg    <= 1'b0;
        end else begin
            started_reg  <= 1'b1;
            inflight_reg <= fifo_rd_en;
            if (transfer) begin
                lane_cnt_reg   <= '0;
                flush_pend_reg <= 1'b0;
            end else begin
                if (inflight_reg) begin
                    lane_cnt_reg <= lane_cnt_reg + CW'(1);
                end
                // A flush with nothing captured or pending is dropped
                if ((state_reg == FILL) && flush && (fill_sum != '0)) begin
                    flush_pend_reg <= 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_reg <= '0;
                end else if (transfer) begin
                    lane_reg <= '0;
                end else if (inflight_reg && (lane_cnt_reg == CW'(gi))) begin
                    lane_reg <= fifo_data_out;
                end
            end

            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg;
`ifdef FIFO_PACKER_PARITY_EN
            assign out_parity[gi] = ^out_data[gi*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    endgenerate

endmodule
